// File: rtl/imm_ext_arbiter.sv
// Two-requester round-robin arbiter feeding a single registered 17->32 bit immediate extender.
// Optional macro IMM_EXT_ZEXT_EN adds per-requester zero-extension selects (a_zext / b_zext).
module imm_ext_arbiter #(
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             a_valid,
  input  logic [16:0]      a_imm,
  input  logic [TAG_W-1:0] a_tag,
`ifdef IMM_EXT_ZEXT_EN
  input  logic             a_zext,
  input  logic             b_zext,
`endif
  input  logic             b_valid,
  input  logic [16:0]      b_imm,
  input  logic [TAG_W-1:0] b_tag,
  output logic             a_ready,
  output logic             b_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic             out_src,
  output logic [TAG_W-1:0] out_tag,
  input  logic             out_ready,
  input  logic             flush
);

  logic        prio;      // 0: A wins a tie, 1: B wins a tie
  logic        space;
  logic        grant_ok;
  logic [16:0] sel_imm;
  logic        sel_zext;
  logic [31:0] ext_data;

  // Grants are gated by reset_n so nothing is accepted while reset is held,
  // even though the cleared output register would otherwise report space.
  assign space    = !out_valid || out_ready;
  assign grant_ok = reset_n && space && !flush;
  assign a_ready  = grant_ok && a_valid && (!b_valid || !prio);
  assign b_ready  = grant_ok && b_valid && (!a_valid ||  prio);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    sel_imm  = a_imm;
    sel_zext = 1'b0;
    if (b_ready) sel_imm = b_imm;
`ifdef IMM_EXT_ZEXT_EN
    sel_zext = b_ready ? b_zext : a_zext;
`endif
    ext_data = sel_zext ? {15'b0, sel_imm} : {{15{sel_imm[16]}}, sel_imm};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      out_tag   <= '0;
      prio      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (a_ready || b_ready) begin
        out_valid <= 1'b1;
        out_data  <= ext_data;
        out_src   <= b_ready;
        out_tag   <= b_ready ? b_tag : a_tag;
        prio      <= a_ready;  // the side not granted gets the next tie
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/imm_ext_arbiter.md
IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 5, width of the destination tag carried with each request.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports a_valid / b_valid  input  1  request valid (A = decode I-type immediate, B = branch-offset unit).
REQ-005 SHALL have ports a_imm / b_imm  input  17  raw immediate field, bit 16 is the sign.
REQ-006 SHALL have ports a_tag / b_tag  input  TAG_W  destination tag, passed through unchanged.
REQ-007 SHALL have ports a_ready / b_ready  output  1  request accepted this cycle (grant).
REQ-008 SHALL have port out_valid  output  1  output register holds a result.
REQ-009 SHALL have port out_data  output  32  extended immediate.
REQ-010 SHALL have port out_src  output  1  0 = result from A, 1 = from B.
REQ-011 SHALL have port out_tag  output  TAG_W  tag of the held result.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result this cycle.
REQ-013 SHALL have port flush  input  1  pipeline flush; discards held result and blocks grants.

Function
REQ-014 SHALL define space = !out_valid | out_ready; no grant when space = 0.
REQ-015 SHALL grant at most one requester per cycle; a_ready and b_ready never both 1.
REQ-016 SHALL, with only one requester valid and space = 1, grant it regardless of priority.
REQ-017 SHALL, with both valid and space = 1, grant the requester indicated by priority pointer prio (0 = A, 1 = B).
REQ-018 SHALL set prio to the non-granted side after every grant; prio unchanged in cycles without a grant.
REQ-019 SHALL derive a_ready/b_ready combinationally from valids, space, prio, flush; ready SHALL NOT depend on its own requester's imm or tag.
REQ-020 SHALL load the output register one cycle after grant: out_data[16:0] = imm[16:0], out_data[31:17] = imm[16] replicated; out_tag, out_src loaded with it (latency 1).
REQ-021 SHALL, when out_valid & out_ready with no new grant, clear out_valid next edge.
REQ-022 SHALL, when out_valid & out_ready with a new grant, load the new result back-to-back (sustained 1 result/cycle).
REQ-023 SHALL hold out_data/out_tag/out_src stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL, when flush = 1, force a_ready = b_ready = 0 and clear out_valid next edge, regardless of out_ready; prio unchanged.
REQ-025 SHALL treat requester valid deassertion without grant as a withdrawn request (no state kept per requester).

Reset
REQ-026 SHALL, while reset_n = 0, drive out_valid = 0, out_data = 0, out_tag = 0, out_src = 0, prio = 0 (A first).
REQ-027 SHALL, on reset assertion mid-operation, discard any held result immediately (asynchronously); no grant until after reset_n deasserts.
REQ-028 SHALL keep a_ready = b_ready = 0 while reset_n = 0.

Configuration
REQ-029 SHALL, with macro IMM_EXT_ZEXT_EN defined, add inputs a_zext and b_zext (1 bit); when the granted request has zext = 1, out_data[31:17] = 0 instead of sign replication.
REQ-030 SHALL, without IMM_EXT_ZEXT_EN, omit a_zext/b_zext and always sign-extend.

Verification
REQ-031 SHALL cover: a_valid only, a_imm = 17'h1FFFF, out_ready = 1 -> next cycle out_valid = 1, out_data = 32'hFFFFFFFF, out_src = 0.
REQ-032 SHALL cover: both valid continuously, out_ready = 1, after reset -> grants alternate A, B, A, B; out_src sequence 0,1,0,1.
REQ-033 SHALL cover: out_valid = 1 with b_imm = 17'h0FFFF held, out_ready = 0 for 3 cycles -> a_ready = b_ready = 0, out_data stays 32'h0000FFFF; out_ready = 1 -> back-to-back load.
REQ-034 SHALL cover: flush = 1 with out_valid = 1, out_ready = 0, a_valid = 1 -> no grant, out_valid = 0 next cycle, prio unchanged.
REQ-035 SHALL cover: reset_n pulsed low mid-stream -> out_valid = 0 immediately, first grant after release goes to A when both valid.
REQ-036 SHALL cover (IMM_EXT_ZEXT_EN): a_imm = 17'h10000, a_zext = 1 -> out_data = 32'h00010000; a_zext = 0 -> 32'hFFFF0000.
